// File: rtl/input_debounce_if.sv
// Raw button inputs and debounced move outputs of the input_debounce block.
interface input_debounce_if;
  logic       tick_input;
  logic [3:0] KEY;
  logic       move_left;
  logic       move_right;
  logic       move_down;
  logic       rotate;
  logic [3:0] held;

  modport master (
    output tick_input, KEY,
    input  move_left, move_right, move_down, rotate, held
  );

  modport slave (
    input  tick_input, KEY,
    output move_left, move_right, move_down, rotate, held
  );
endinterface

// File: rtl/input_debounce.sv
// Push-button conditioning: 2-flop sync, tick-sampled debounce, and
// delayed auto-repeat (DAS/ARR) move pulses for left/right/down plus a one-shot rotate.
module input_debounce #(
  parameter int unsigned STABLE_N  = 3,
  parameter int unsigned DAS_TICKS = 20,
  parameter int unsigned ARR_TICKS = 5
) (
  input logic             CLOCK_50,
  input logic             reset,
  input_debounce_if.slave bus
);
  localparam int unsigned NBTN = 4;
  localparam int unsigned NDIR = 3;
  localparam int unsigned CW   = 8;

  localparam logic [CW-1:0] STABLE_W = CW'(STABLE_N);
  localparam logic [CW-1:0] DAS_W    = CW'(DAS_TICKS);
  localparam logic [CW-1:0] ARR_W    = CW'(ARR_TICKS);
  localparam logic [CW-1:0] ONE_W    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DAS    = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [NBTN-1:0] key_meta_q;
  logic [NBTN-1:0] key_sync_q;
  logic [NBTN-1:0] pressed_c;

  logic [CW-1:0]   stab_cnt_q [NBTN];
  logic [CW-1:0]   stab_cnt_d [NBTN];
  logic [NBTN-1:0] held_q;
  logic [NBTN-1:0] held_d;
  logic [NBTN-1:0] held_rise_c;
  logic [NBTN-1:0] held_fall_c;

  // Directional lanes: [0]=down, [1]=right, [2]=left (KEY bits 1..3)
  logic [NDIR-1:0] dir_held_c;
  logic [NDIR-1:0] dir_rise_c;
  logic [NDIR-1:0] dir_fall_c;
  rep_state_e      rep_state_q [NDIR];
  rep_state_e      rep_state_d [NDIR];
  logic [CW-1:0]   rep_cnt_q   [NDIR];
  logic [CW-1:0]   rep_cnt_d   [NDIR];
  logic [NDIR-1:0] fire_c;
  logic            lr_block_c;

  logic move_left_q;
  logic move_right_q;
  logic move_down_q;
  logic rotate_q;

  // Synchronizers park at "released" (KEY is active-low)
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_meta_q <= '1;
      key_sync_q <= '1;
    end else begin
      key_meta_q <= bus.KEY;
      key_sync_q <= key_meta_q;
    end
  end

  assign pressed_c = ~key_sync_q;

  // Debounce: count consecutive differing samples, toggle held at STABLE_N
  always_comb begin
    held_d = held_q;
    for (int b = 0; b < NBTN; b++) begin
      stab_cnt_d[b] = stab_cnt_q[b];
      if (bus.tick_input) begin
        if (pressed_c[b] == held_q[b]) begin
          stab_cnt_d[b] = '0;
        end else if (stab_cnt_q[b] + ONE_W == STABLE_W) begin
          held_d[b]     = ~held_q[b];
          stab_cnt_d[b] = '0;
        end else begin
          stab_cnt_d[b] = stab_cnt_q[b] + ONE_W;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held_q <= '0;
      for (int b = 0; b < NBTN; b++) stab_cnt_q[b] <= '0;
    end else begin
      held_q <= held_d;
      for (int b = 0; b < NBTN; b++) stab_cnt_q[b] <= stab_cnt_d[b];
    end
  end

  assign held_rise_c = held_d & ~held_q;
  assign held_fall_c = ~held_d & held_q;
  assign dir_held_c  = held_d[NBTN-1:1];
  assign dir_rise_c  = held_rise_c[NBTN-1:1];
  assign dir_fall_c  = held_fall_c[NBTN-1:1];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NDIR; j++) begin
        rep_state_q[j] <= ST_IDLE;
        rep_cnt_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NDIR; j++) begin
        rep_state_q[j] <= rep_state_d[j];
        rep_cnt_q[j]   <= rep_cnt_d[j];
      end
    end
  end

  // Repeat FSM next state; a falling held always wins and returns to IDLE
  always_comb begin
    for (int j = 0; j < NDIR; j++) begin
      rep_state_d[j] = rep_state_q[j];
      rep_cnt_d[j]   = rep_cnt_q[j];
      if (dir_fall_c[j]) begin
        rep_state_d[j] = ST_IDLE;
        rep_cnt_d[j]   = '0;
      end else begin
        unique case (rep_state_q[j])
          ST_IDLE: begin
            if (dir_rise_c[j]) begin
              rep_state_d[j] = ST_DAS;
              rep_cnt_d[j]   = '0;
            end
          end
          ST_DAS: begin
            if (bus.tick_input && dir_held_c[j]) begin
              if (rep_cnt_q[j] + ONE_W == DAS_W) begin
                rep_state_d[j] = ST_REPEAT;
                rep_cnt_d[j]   = '0;
              end else begin
                rep_cnt_d[j] = rep_cnt_q[j] + ONE_W;
              end
            end
          end
          ST_REPEAT: begin
            if (bus.tick_input && dir_held_c[j]) begin
              if (rep_cnt_q[j] + ONE_W == ARR_W) rep_cnt_d[j] = '0;
              else                               rep_cnt_d[j] = rep_cnt_q[j] + ONE_W;
            end
          end
          default: begin
            rep_state_d[j] = ST_IDLE;
            rep_cnt_d[j]   = '0;
          end
        endcase
      end
    end
  end

  // Repeat FSM pulse decode
  always_comb begin
    fire_c = '0;
    for (int j = 0; j < NDIR; j++) begin
      unique case (rep_state_q[j])
        ST_IDLE:   fire_c[j] = dir_rise_c[j];
        ST_DAS:    fire_c[j] = bus.tick_input & dir_held_c[j] & (rep_cnt_q[j] + ONE_W == DAS_W);
        ST_REPEAT: fire_c[j] = bus.tick_input & dir_held_c[j] & (rep_cnt_q[j] + ONE_W == ARR_W);
        default:   fire_c[j] = 1'b0;
      endcase
    end
  end

  // Left+right together cancel both pulses while their FSMs keep counting
  assign lr_block_c = held_d[3] & held_d[2];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      move_down_q  <= 1'b0;
      move_right_q <= 1'b0;
      move_left_q  <= 1'b0;
      rotate_q     <= 1'b0;
    end else begin
      move_down_q  <= fire_c[0];
      move_right_q <= fire_c[1] & ~lr_block_c;
      move_left_q  <= fire_c[2] & ~lr_block_c;
      rotate_q     <= held_rise_c[0];
    end
  end

  assign bus.move_left  = move_left_q;
  assign bus.move_right = move_right_q;
  assign bus.move_down  = move_down_q;
  assign bus.rotate     = rotate_q;
  assign bus.held       = held_q;
endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: a tick-level reference model predicts
// held changes and move pulses; a negedge monitor matches them against the DUT.
module tb_input_debounce;
  localparam int unsigned STABLE_N  = 3;
  localparam int unsigned DAS_TICKS = 20;
  localparam int unsigned ARR_TICKS = 5;

  logic clk = 1'b0;
  logic rst;

  input_debounce_if bus();

  input_debounce #(
    .STABLE_N (STABLE_N),
    .DAS_TICKS(DAS_TICKS),
    .ARR_TICKS(ARR_TICKS)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // pulses packed as {move_left, move_right, move_down, rotate}
  typedef struct {
    int unsigned tick;
    logic [3:0]  held;
    logic [3:0]  pulses;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned model_ticks = 0;
  int unsigned seen_ticks = 0;

  logic [3:0] m_held;
  int         m_run[4];
  int         m_age[4];

  function automatic void model_reset();
    m_held = '0;
    for (int b = 0; b < 4; b++) begin
      m_run[b] = 0;
      m_age[b] = -1;
    end
  endfunction

  // One sample tick: debounce by run length, repeat pulses from hold age
  function automatic void model_tick(input logic [3:0] key);
    logic [3:0] prev;
    logic [3:0] p;
    logic       lvl;
    int         das;
    int         arr;
    ev_t        ev;
    das  = int'(DAS_TICKS);
    arr  = int'(ARR_TICKS);
    prev = m_held;
    p    = '0;
    model_ticks++;
    for (int b = 0; b < 4; b++) begin
      lvl = ~key[b];
      if (lvl != m_held[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(STABLE_N)) begin
          m_held[b] = lvl;
          m_run[b]  = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    p[0] = m_held[0] & ~prev[0];
    for (int b = 1; b < 4; b++) begin
      if (!m_held[b]) begin
        m_age[b] = -1;
      end else begin
        m_age[b] = prev[b] ? m_age[b] + 1 : 0;
        if (m_age[b] == 0 || (m_age[b] >= das && (m_age[b] - das) % arr == 0))
          p[b] = 1'b1;
      end
    end
    if (m_held[3] && m_held[2]) p[3:2] = 2'b00;
    if (p != 4'b0000 || m_held != prev) begin
      ev.tick   = model_ticks;
      ev.held   = m_held;
      ev.pulses = p;
      exp_q.push_back(ev);
    end
  endfunction

  always @(posedge clk) begin
    if (!rst && bus.tick_input) seen_ticks++;
  end

  // Monitor: any pulse or held change is an output event to be matched
  initial begin
    logic [3:0] last_held;
    logic [3:0] cur_p;
    ev_t        e;
    last_held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_held = '0;
      end else begin
        cur_p = {bus.move_left, bus.move_right, bus.move_down, bus.rotate};
        if (cur_p != 4'b0000 || bus.held != last_held) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: tick=%0d held=%b pulses=%b, expected no event",
                     seen_ticks, bus.held, cur_p);
          end else begin
            e = exp_q.pop_front();
            if (e.tick != seen_ticks || e.held != bus.held || e.pulses != cur_p) begin
              n_err++;
              $display("FAIL event: got tick=%0d held=%b pulses=%b, expected tick=%0d held=%b pulses=%b",
                       seen_ticks, bus.held, cur_p, e.tick, e.held, e.pulses);
            end
          end
        end
        last_held = bus.held;
      end
    end
  end

  task automatic one_tick(input logic [3:0] key);
    int gap;
    gap = $urandom_range(3, 8);
    bus.KEY = key;
    repeat (gap) @(posedge clk);
    #1;
    bus.tick_input = 1'b1;
    model_tick(key);
    @(posedge clk);
    #1;
    bus.tick_input = 1'b0;
  endtask

  task automatic run(input logic [3:0] key, input int n);
    for (int i = 0; i < n; i++) one_tick(key);
  endtask

  task automatic check_outputs_zero(input string name);
    logic [7:0] act;
    act = {bus.held, bus.move_left, bus.move_right, bus.move_down, bus.rotate};
    n_cmp++;
    if (act != 8'h00) begin
      n_err++;
      $display("FAIL %s: held/pulses=%b, expected 00000000", name, act);
    end
  endtask

  task automatic reset_mid_run();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_before_reset: %0d events pending, expected 0", exp_q.size());
    end
    exp_q.delete();
    n_cmp++;
    if (bus.held != 4'b0010) begin
      n_err++;
      $display("FAIL held_before_reset: held=%b, expected 0010", bus.held);
    end
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("during_reset");
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] key;
    int         n;
    rst            = 1'b1;
    bus.KEY        = 4'hF;
    bus.tick_input = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    rst = 1'b0;

    // Left press: accepted on third tick, then DAS/ARR repeats
    run(4'b0111, 30);
    run(4'b1111, 4);
    // Right glitching 2 low / 1 high never accepted
    repeat (10) begin
      run(4'b1011, 2);
      run(4'b1111, 1);
    end
    // Down held 40 ticks past acceptance
    run(4'b1101, 43);
    run(4'b1111, 4);
    // Rotate held 60 ticks, then released
    run(4'b1110, 60);
    run(4'b1111, 4);
    // Left+right together, then right released
    run(4'b0011, 25);
    run(4'b0111, 30);
    run(4'b1111, 4);
    // Reset while down is repeating, key kept low through deassert
    run(4'b1101, 30);
    reset_mid_run();
    run(4'b1101, 10);
    run(4'b1111, 4);

    // Random held segments
    for (int s = 0; s < 80; s++) begin
      key = 4'($urandom);
      n   = int'($urandom_range(1, 35));
      run(key, n);
    end
    // Random per-tick chatter
    for (int i = 0; i < 200; i++) run(4'($urandom), 1);
    run(4'b1111, 5);

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_at_end: %0d events pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter STABLE_N, default 3: consecutive tick_input samples (~30 ms) required to accept a button level change; legal 1..255.
REQ-002 Parameter DAS_TICKS, default 20: held ticks (~200 ms) after the first press pulse before auto-repeat starts; legal 1..255.
REQ-003 Parameter ARR_TICKS, default 5: ticks (~50 ms) between auto-repeat pulses; legal 1..255.
REQ-004 CLOCK_50  input  1  system clock, 50 MHz, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick_input  input  1  one-cycle sample strobe, ~100 Hz, from the input tick generator.
REQ-007 KEY  input  4  raw push buttons, active-low, asynchronous; [0]=rotate, [1]=down, [2]=right, [3]=left.
REQ-008 move_left  output  1  one-cycle move pulse.
REQ-009 move_right  output  1  one-cycle move pulse.
REQ-010 move_down  output  1  one-cycle soft-drop pulse.
REQ-011 rotate  output  1  one-cycle rotate pulse.
REQ-012 held  output  4  debounced pressed level per button, active-high, same bit order as KEY.

Function
REQ-013 Each KEY bit SHALL pass through a 2-flop synchronizer and be inverted before any other use.
REQ-014 Debounce state SHALL be sampled only on cycles with tick_input=1; with tick_input=0, debounce, DAS and repeat state SHALL hold.
REQ-015 Per button, an 8-bit stability counter SHALL increment on each tick whose synchronized level differs from held, and clear on each tick whose level equals held.
REQ-016 On the tick where the differing sample count reaches STABLE_N, held SHALL toggle at that clock edge and the counter SHALL clear.
REQ-017 A single tick with a matching sample SHALL restart the count, so glitches shorter than STABLE_N ticks never change held.
REQ-018 Per directional button (left, right, down), an FSM SHALL run with states IDLE, DAS and REPEAT, using an 8-bit tick counter.
REQ-019 IDLE->DAS at the clock edge where held rises; the corresponding pulse SHALL assert in the following cycle for exactly one cycle; counter <= 0.
REQ-020 In DAS, each tick with held=1: counter+1; on the tick where counter+1 == DAS_TICKS, one pulse SHALL fire, state SHALL become REPEAT and counter SHALL clear.
REQ-021 In REPEAT, each tick with held=1: counter+1; on the tick where counter+1 == ARR_TICKS, one pulse SHALL fire and counter SHALL clear.
REQ-022 From any state, held falling SHALL force IDLE with counter 0 at that edge and no pulse.
REQ-023 Rotate SHALL pulse once per held rising edge, with no auto-repeat.
REQ-024 While held[3] and held[2] are both 1, move_left and move_right SHALL both be suppressed, but their FSMs SHALL keep running; pulses resume per FSM when one is released.
REQ-025 All outputs SHALL be registered, and no output SHALL stay high for more than one cycle except held.
REQ-026 Left, right and down pulses MAY coincide with each other and with rotate (subject to REQ-024).

Reset
REQ-027 While reset=1, the synchronizers SHALL hold "released", all counters SHALL be 0, all FSMs SHALL be IDLE, and all outputs SHALL be 0, asynchronously.
REQ-028 A button held through reset deassertion SHALL be treated as a new press: held rises after STABLE_N ticks, followed by a normal first pulse.
REQ-029 Reset asserted mid-DAS or mid-REPEAT SHALL abort immediately with no trailing pulse.

Verification
REQ-030 KEY[3]=0 held steady, tick every 10 cycles -> held[3]=1 at the 3rd tick edge; move_left=1 for exactly 1 cycle after it.
REQ-031 KEY[2] low for 2 ticks, high 1 tick, repeated 10 times -> held[2] stays 0, move_right never pulses.
REQ-032 KEY[1] held for 40 ticks after acceptance -> move_down pulses at ticks 0, 20, 25, 30, 35, 40 relative to held rise (6 pulses).
REQ-033 KEY[0] held for 60 ticks -> exactly one rotate pulse; release plus 3 ticks -> held[0]=0 with no pulse.
REQ-034 KEY[3] and KEY[2] pressed together -> held=4'b1100, no move_left/move_right; release KEY[2] after 22 ticks -> move_left resumes on the next REPEAT boundary.
REQ-035 reset pulsed while KEY[1] is in REPEAT -> all outputs 0 in the same cycle; after deassert with KEY[1] still low, the first move_down occurs 3 ticks later.
